// File: rtl/signature_verify_engine.sv
// Constant-time signature check: expected tag = hash ^ key[id], compared WORD_W bits per cycle.
// Optional consecutive-failure lockout is compiled in with `define SIG_VERIFY_LOCKOUT_EN.
module signature_verify_engine #(
    parameter int unsigned  SIG_W      = 256,
    parameter int unsigned  WORD_W     = 32,
    parameter int unsigned  NUM_KEYS   = 4,
    parameter int unsigned  FAIL_LIMIT = 3,
    localparam int unsigned KID_W      = $clog2(NUM_KEYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_wr_en,
    input  logic [KID_W-1:0] key_wr_id,
    input  logic [SIG_W-1:0] key_wr_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KID_W-1:0] req_key_id,
    input  logic [SIG_W-1:0] req_hash,
    input  logic [SIG_W-1:0] req_sig,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_match,
    output logic             rsp_key_err,
    output logic             busy,
    output logic             locked
);
    localparam int unsigned NWORDS = SIG_W / WORD_W;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {StIdle, StCompare, StResp} state_e;
    state_e state_q, state_d;

    logic [SIG_W-1:0]    key_mem [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_loaded_q;
    logic [SIG_W-1:0]    hash_q, sig_q, key_q;
    logic                loaded_q;
    logic [WORD_W-1:0]   diff_q, diff_next;
    logic [CNT_W-1:0]    word_cnt_q;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_match_q, rsp_match_d;
    logic                rsp_key_err_q, rsp_key_err_d;
    logic                busy_q, busy_d;
    logic                locked_q;
    logic                accept, last_word, rsp_hs;

    assign req_ready   = (state_q == StIdle) && !locked_q;
    assign accept      = req_valid && req_ready;
    assign last_word   = (state_q == StCompare) && (word_cnt_q == CNT_W'(NWORDS - 1));
    assign rsp_hs      = (state_q == StResp) && rsp_ready;
    assign diff_next   = diff_q | (sig_q[WORD_W-1:0] ^ hash_q[WORD_W-1:0] ^ key_q[WORD_W-1:0]);

    assign rsp_valid   = rsp_valid_q;
    assign rsp_match   = rsp_match_q;
    assign rsp_key_err = rsp_key_err_q;
    assign busy        = busy_q;
    assign locked      = locked_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept)    state_d = StCompare;
            StCompare: if (last_word) state_d = StResp;
            StResp:    if (rsp_hs)    state_d = StIdle;
            default:                  state_d = StIdle;
        endcase
    end

    // Registered outputs are computed from the upcoming state so they change with it.
    always_comb begin
        rsp_valid_d   = (state_d == StResp);
        busy_d        = (state_d != StIdle);
        rsp_match_d   = rsp_match_q;
        rsp_key_err_d = rsp_key_err_q;
        if (state_d != StResp) begin
            rsp_match_d   = 1'b0;
            rsp_key_err_d = 1'b0;
        end else if (state_q == StCompare) begin
            rsp_match_d   = (diff_next == '0) && loaded_q;
            rsp_key_err_d = !loaded_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_loaded_q  <= '0;
            loaded_q      <= 1'b0;
            diff_q        <= '0;
            word_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_match_q   <= 1'b0;
            rsp_key_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            if (key_wr_en) begin
                key_loaded_q[key_wr_id] <= 1'b1;
            end
            if (accept) begin
                loaded_q   <= key_loaded_q[req_key_id];
                diff_q     <= '0;
                word_cnt_q <= '0;
            end else if (state_q == StCompare) begin
                diff_q     <= diff_next;
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
            rsp_valid_q   <= rsp_valid_d;
            rsp_match_q   <= rsp_match_d;
            rsp_key_err_q <= rsp_key_err_d;
            busy_q        <= busy_d;
        end
    end

    // Key storage and the request snapshot need no reset; the snapshot reads the pre-write key.
    always_ff @(posedge clk) begin
        if (key_wr_en) begin
            key_mem[key_wr_id] <= key_wr_data;
        end
        if (accept) begin
            hash_q <= req_hash;
            sig_q  <= req_sig;
            key_q  <= key_mem[req_key_id];
        end else if (state_q == StCompare) begin
            hash_q <= hash_q >> WORD_W;
            sig_q  <= sig_q >> WORD_W;
            key_q  <= key_q >> WORD_W;
        end
    end

`ifdef SIG_VERIFY_LOCKOUT_EN
    localparam int unsigned FCNT_W = $clog2(FAIL_LIMIT + 1);
    logic [FCNT_W-1:0] fail_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fail_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else if (rsp_hs) begin
            if (rsp_match_q) begin
                fail_cnt_q <= '0;
            end else if (fail_cnt_q < FCNT_W'(FAIL_LIMIT)) begin
                fail_cnt_q <= fail_cnt_q + FCNT_W'(1);
            end
            // Lock on the limit-reaching handshake so no request slips in the following cycle.
            if (!rsp_match_q && (fail_cnt_q >= FCNT_W'(FAIL_LIMIT - 1))) begin
                locked_q <= 1'b1;
            end
        end
    end
`else
    logic unused_fail_limit;
    assign unused_fail_limit = (FAIL_LIMIT != 0);
    assign locked_q          = 1'b0;
`endif

endmodule
